// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/operand/result bundle between the control unit and mult_div_unit
interface mult_div_unit_if #(
   parameter int WIDTH = 32
);
   logic             mult;
   logic             div;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] hi;
   logic [WIDTH-1:0] lo;
   logic             busy;
   logic             done;
   logic             divzero;
   logic             overflowmult;

   modport master (
      output mult, div, a, b,
      input  hi, lo, busy, done, divzero, overflowmult
   );

   modport slave (
      input  mult, div, a, b,
      output hi, lo, busy, done, divzero, overflowmult
   );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multicycle signed Booth multiply / restoring divide into HI/LO
// Optional macro MULTDIV_OVERFLOW_EN enables the overflowmult product-range flag.
module mult_div_unit #(
   parameter int WIDTH = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   mult_div_unit_if.slave  bus_io
);
   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MULT,
      S_DIV,
      S_DONE
   } state_e;

   state_e           state_q;
   logic [WIDTH:0]   acc_q;
   logic [WIDTH-1:0] q_q;
   logic [WIDTH-1:0] m_q;
   logic             qm1_q;
   logic             neg_quot_q;
   logic             neg_rem_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             busy_q;
   logic             done_q;
   logic             divzero_q;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   m_ext;
   logic [WIDTH:0]   booth_sum;
   logic [WIDTH:0]   mul_acc_d;
   logic [WIDTH-1:0] mul_q_d;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH:0]   div_diff;
   logic [WIDTH:0]   div_acc_d;
   logic [WIDTH-1:0] div_q_d;
   logic [WIDTH-1:0] quot_fix;
   logic [WIDTH-1:0] rem_fix;

   always_comb begin
      a_mag = bus_io.a[WIDTH-1] ? -bus_io.a : bus_io.a;
      b_mag = bus_io.b[WIDTH-1] ? -bus_io.b : bus_io.b;

      // acc carries one guard bit so subtracting the most-negative multiplicand cannot overflow
      m_ext = {m_q[WIDTH-1], m_q};
      case ({q_q[0], qm1_q})
         2'b01:   booth_sum = acc_q + m_ext;
         2'b10:   booth_sum = acc_q - m_ext;
         default: booth_sum = acc_q;
      endcase
      mul_acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
      mul_q_d   = {booth_sum[0], q_q[WIDTH-1:1]};

      div_shift = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, m_q};
      if (!div_diff[WIDTH]) begin
         div_acc_d = div_diff;
         div_q_d   = {q_q[WIDTH-2:0], 1'b1};
      end else begin
         div_acc_d = div_shift;
         div_q_d   = {q_q[WIDTH-2:0], 1'b0};
      end

      quot_fix = neg_quot_q ? -q_q : q_q;
      rem_fix  = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_IDLE;
         acc_q      <= '0;
         q_q        <= '0;
         m_q        <= '0;
         qm1_q      <= 1'b0;
         neg_quot_q <= 1'b0;
         neg_rem_q  <= 1'b0;
         cnt_q      <= '0;
         hi_q       <= '0;
         lo_q       <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         divzero_q  <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         divzero_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus_io.mult) begin
                  acc_q   <= '0;
                  q_q     <= bus_io.a;
                  m_q     <= bus_io.b;
                  qm1_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_MULT;
               end else if (bus_io.div) begin
                  busy_q <= 1'b1;
                  if (bus_io.b != '0) begin
                     acc_q      <= '0;
                     q_q        <= a_mag;
                     m_q        <= b_mag;
                     neg_quot_q <= bus_io.a[WIDTH-1] ^ bus_io.b[WIDTH-1];
                     neg_rem_q  <= bus_io.a[WIDTH-1];
                     cnt_q      <= '0;
                     state_q    <= S_DIV;
                  end else begin
                     done_q    <= 1'b1;
                     divzero_q <= 1'b1;
                     state_q   <= S_DONE;
                  end
               end
            end
            S_MULT: begin
               if (cnt_q == CNT_LAST) begin
                  hi_q    <= acc_q[WIDTH-1:0];
                  lo_q    <= q_q;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  acc_q <= mul_acc_d;
                  q_q   <= mul_q_d;
                  qm1_q <= q_q[0];
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DIV: begin
               if (cnt_q == CNT_LAST) begin
                  hi_q    <= rem_fix;
                  lo_q    <= quot_fix;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  acc_q <= div_acc_d;
                  q_q   <= div_q_d;
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

`ifdef MULTDIV_OVERFLOW_EN
   logic ovf_q;

   // Valid only during DONE; cleared on every other cycle so divides always report 0
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         ovf_q <= 1'b0;
      end else if (state_q == S_MULT && cnt_q == CNT_LAST) begin
         ovf_q <= (acc_q[WIDTH-1:0] != {WIDTH{q_q[WIDTH-1]}});
      end else begin
         ovf_q <= 1'b0;
      end
   end

   assign bus_io.overflowmult = ovf_q;
`else
   assign bus_io.overflowmult = 1'b0;
`endif

   assign bus_io.hi      = hi_q;
   assign bus_io.lo      = lo_q;
   assign bus_io.busy    = busy_q;
   assign bus_io.done    = done_q;
   assign bus_io.divzero = divzero_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit at WIDTH=32
module tb_mult_div_unit;
   localparam int W = 32;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mult_div_unit_if #(.WIDTH(W)) md ();

   mult_div_unit #(.WIDTH(W)) dut (
      .clk_i  (clk),
      .reset_i(reset),
      .bus_io (md.slave)
   );

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      logic        dz;
      logic        ovf;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          failures = 0;
   logic [31:0] model_hi = '0;
   logic [31:0] model_lo = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic push_expect(input logic m, input logic d, input logic [31:0] av, input logic [31:0] bv);
      exp_t   e;
      longint sa;
      longint sbv;
      longint p;
      sa    = longint'($signed(av));
      sbv   = longint'($signed(bv));
      e.dz  = 1'b0;
      e.ovf = 1'b0;
      if (m) begin
         p        = sa * sbv;
         model_hi = p[63:32];
         model_lo = p[31:0];
`ifdef MULTDIV_OVERFLOW_EN
         e.ovf = (p > 64'sd2147483647) || (p < -64'sd2147483648);
`endif
      end else if (d) begin
         if (bv == '0) begin
            e.dz = 1'b1;
         end else begin
            p        = sa / sbv;
            model_lo = p[31:0];
            p        = sa % sbv;
            model_hi = p[31:0];
         end
      end
      e.hi = model_hi;
      e.lo = model_lo;
      exp_q.push_back(e);
   endtask

   task automatic run_op(input string tag, input logic m, input logic d,
                         input logic [31:0] av, input logic [31:0] bv, input bit inject);
      exp_t        e;
      int          cyc;
      int          busy_cyc;
      int          done_cnt;
      int          done_at;
      int          idle_at;
      int          stray_dz;
      logic [31:0] prev_hi;
      logic [31:0] prev_lo;
      bit          is_dz;
      prev_hi  = model_hi;
      prev_lo  = model_lo;
      is_dz    = !m && d && (bv == '0);
      busy_cyc = 0;
      done_cnt = 0;
      done_at  = -1;
      idle_at  = -1;
      stray_dz = 0;
      push_expect(m, d, av, bv);
      @(negedge clk);
      md.mult = m;
      md.div  = d;
      md.a    = av;
      md.b    = bv;
      @(posedge clk);
      #1;
      md.mult = 1'b0;
      md.div  = 1'b0;
      md.a    = $urandom;
      md.b    = $urandom;
      cyc     = 0;
      while (cyc < 200) begin
         @(negedge clk);
         cyc++;
         if (md.busy) busy_cyc++;
         if (md.divzero && !md.done) stray_dz++;
         if (cyc == 10 && !is_dz) begin
            check({tag, "_hold_hi"}, 64'(md.hi), 64'(prev_hi));
            check({tag, "_hold_lo"}, 64'(md.lo), 64'(prev_lo));
         end
         if (md.done) begin
            done_cnt++;
            done_at = cyc;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check({tag, "_hi"}, 64'(md.hi), 64'(e.hi));
               check({tag, "_lo"}, 64'(md.lo), 64'(e.lo));
               check({tag, "_divzero"}, 64'(md.divzero), 64'(e.dz));
               check({tag, "_ovf"}, 64'(md.overflowmult), 64'(e.ovf));
            end else begin
               check({tag, "_sb_empty"}, 64'(1), 64'(0));
            end
         end
         if (inject && cyc == 5) begin
            md.mult = 1'b1;
            md.a    = 32'h7FFF_FFFF;
            md.b    = 32'h0000_0011;
         end
         if (inject && cyc == 6) md.mult = 1'b0;
         if (done_cnt > 0 && !md.busy) begin
            idle_at = cyc;
            break;
         end
      end
      check({tag, "_done_count"}, 64'(done_cnt), 64'(1));
      check({tag, "_done_at"}, 64'(done_at), is_dz ? 64'(1) : 64'(W + 2));
      check({tag, "_busy_cycles"}, 64'(busy_cyc), is_dz ? 64'(1) : 64'(W + 2));
      check({tag, "_idle_at"}, 64'(idle_at), is_dz ? 64'(2) : 64'(W + 3));
      check({tag, "_stray_divzero"}, 64'(stray_dz), 64'(0));
   endtask

   initial begin
      int stray_done;
      logic [31:0] ra;
      logic [31:0] rb;
      logic        rm;

      reset   = 1'b1;
      md.mult = 1'b0;
      md.div  = 1'b0;
      md.a    = '0;
      md.b    = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_hi", 64'(md.hi), 64'(0));
      check("rst_lo", 64'(md.lo), 64'(0));
      check("rst_busy", 64'(md.busy), 64'(0));
      check("rst_done", 64'(md.done), 64'(0));
      check("rst_divzero", 64'(md.divzero), 64'(0));
      check("rst_ovf", 64'(md.overflowmult), 64'(0));
      reset = 1'b0;

      run_op("mul_7xm3", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
      check("mul_7xm3_const_hi", 64'(model_hi), 64'(32'hFFFF_FFFF));
      check("mul_7xm3_const_lo", 64'(model_lo), 64'(32'hFFFF_FFEB));
      run_op("div_m7_2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
      run_op("div_7_m2", 1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0);
      run_op("preload_95_10", 1'b0, 1'b1, 32'd95, 32'd10, 1'b0);
      run_op("div0", 1'b0, 1'b1, 32'd1234, 32'd0, 1'b0);
      check("div0_keep_hi", 64'(md.hi), 64'(5));
      check("div0_keep_lo", 64'(md.lo), 64'(9));
      run_op("minneg_div_m1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
      run_op("both_strobes", 1'b1, 1'b1, 32'd6, 32'd7, 1'b0);
      run_op("busy_ignore", 1'b1, 1'b0, 32'h0001_2345, 32'hFFFF_0001, 1'b1);
      run_op("minneg_sq", 1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
      run_op("div_minneg_3", 1'b0, 1'b1, 32'h8000_0000, 32'd3, 1'b0);

      // reset abort in the middle of a multiply
      @(negedge clk);
      md.mult = 1'b1;
      md.a    = 32'h0000_1234;
      md.b    = 32'h0000_5678;
      @(posedge clk);
      #1;
      md.mult = 1'b0;
      repeat (10) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      check("abort_hi", 64'(md.hi), 64'(0));
      check("abort_lo", 64'(md.lo), 64'(0));
      check("abort_busy", 64'(md.busy), 64'(0));
      check("abort_done", 64'(md.done), 64'(0));
      check("abort_divzero", 64'(md.divzero), 64'(0));
      check("abort_ovf", 64'(md.overflowmult), 64'(0));
      reset = 1'b0;
      model_hi   = '0;
      model_lo   = '0;
      stray_done = 0;
      repeat (60) begin
         @(negedge clk);
         if (md.done || md.busy) stray_done++;
      end
      check("abort_no_done", 64'(stray_done), 64'(0));
      run_op("mul_3x4", 1'b1, 1'b0, 32'd3, 32'd4, 1'b0);

      run_op("ovf_big", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 1'b0);
      run_op("ovf_small", 1'b1, 1'b0, 32'd3, 32'hFFFF_FFFC, 1'b0);
      run_op("div_after_ovf", 1'b0, 1'b1, 32'h7FFF_FFFF, 32'h0000_0002, 1'b0);

      for (int i = 0; i < 8; i++) begin
         rm = 1'($urandom_range(0, 1));
         ra = $urandom;
         rb = (i == 5) ? 32'd0 : $urandom;
         if (i == 3) rb = 32'h0000_0007;
         run_op($sformatf("rand%0d", i), rm, ~rm, ra, rb, 1'b0);
      end

      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
